vscale_share_splitter: RTL

//   Converts one merged (unmasked) DWIDTH-bit word into SHARES Boolean shares
//   for the DOM-protected datapath. It is the counterpart of the merged operand

---
 rtl/vscale_share_splitter.sv | 102 ++++++++++
 1 files changed

// File: rtl/vscale_share_splitter.sv
// Splits one merged word into SHARES Boolean shares using fresh PRNG masks.
// Single-entry buffer with valid/ready on both sides and a rejected-draw counter.
module vscale_share_splitter #(
   parameter int DWIDTH = 32,
   parameter int SHARES = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DWIDTH-1:0]            in_data,
   output logic                         rnd_req,
   input  logic                         rnd_valid,
   input  logic [(SHARES-1)*DWIDTH-1:0] rnd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SHARES*DWIDTH-1:0]     out_shares,
   output logic [7:0]                   rnd_reject_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      HOLD     = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [DWIDTH-1:0]          word_q, word_d;
   logic [SHARES*DWIDTH-1:0]   shares_q, shares_d;
   logic [7:0]                 rej_q, rej_d;

   logic                       any_zero;
   logic [DWIDTH-1:0]          mask_x;

   // A draw with any all-zero slice would leave that share equal to a
   // constant, so it is rejected rather than used.
   always_comb begin
      any_zero = 1'b0;
      mask_x   = '0;
      for (int k = 0; k < SHARES-1; k++) begin
         if (rnd_data[k*DWIDTH +: DWIDTH] == '0) begin
            any_zero = 1'b1;
         end
         mask_x = mask_x ^ rnd_data[k*DWIDTH +: DWIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      shares_d = shares_q;
      rej_d    = rej_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_data;
               state_d = WAIT_RND;
            end
         end
         WAIT_RND: begin
            if (rnd_valid) begin
               if (any_zero) begin
                  if (rej_q != 8'hFF) begin
                     rej_d = rej_q + 8'd1;
                  end
               end else begin
                  shares_d = {rnd_data, word_q ^ mask_x};
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         word_q   <= '0;
         shares_q <= '0;
         rej_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         shares_q <= shares_d;
         rej_q    <= rej_d;
      end
   end

   // Handshake outputs depend on state only, so async reset shows up at once.
   assign in_ready       = (state_q == IDLE);
   assign rnd_req        = (state_q == WAIT_RND);
   assign out_valid      = (state_q == HOLD);
   assign out_shares     = shares_q;
   assign rnd_reject_cnt = rej_q;

endmodule
